// File: rtl/prog_loader_pkg.sv
// Shared types for the program loader: state codes and data widths.
// Imported by byte_packer and prog_loader.
package prog_loader_pkg;

  localparam int BYTE_W  = 8;
  localparam int INSTR_W = 16;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    HI   = 4'd1,
    LO   = 4'd2,
    WR   = 4'd3,
    REL  = 4'd4,
    RUN  = 4'd5,
    HALT = 4'd6,
    CK   = 4'd7,
    ERR  = 4'd8
  } state_t;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Packs two bytes big-endian into one instruction word.
// Ports: clk, rst (sync, low), take_hi/take_lo, byte_in, word, word_valid.
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               take_hi,
  input  logic               take_lo,
  input  logic [BYTE_W-1:0]  byte_in,
  output logic [INSTR_W-1:0] word,
  output logic               word_valid
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= take_lo;
      if (take_hi)
        word[15:8] <= byte_in;
      if (take_lo)
        word[7:0] <= byte_in;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: writes WORDS instruction words, then
// releases the core's PC and tracks run/halt. Option: LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int WORDS = 8,
  parameter int AW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BYTE_W-1:0]  byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic [INSTR_W-1:0] ext_data,
  output logic               ext_we,
  output logic [AW-1:0]      load_addr,
  output logic               PC_rst,
  input  logic               cpu_done,
  output logic               busy,
  output logic               running,
`ifdef LOADER_CHECKSUM_EN
  output logic               err,
`endif
  output logic               halted
);

  state_t state_q, state_d;
  logic   hs, take_hi, take_lo, last;

  // start wins over a simultaneous handshake
  assign hs      = byte_valid & byte_ready & ~start;
  assign take_hi = hs & (state_q == HI);
  assign take_lo = hs & (state_q == LO);
  assign last    = load_addr == AW'(WORDS - 1);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .take_hi    (take_hi),
    .take_lo    (take_lo),
    .byte_in    (byte_in),
    .word       (ext_data),
    .word_valid (ext_we)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q;
  logic              ck_hs;

  assign ck_hs = hs & (state_q == CK);
  assign err   = state_q == ERR;

  always_ff @(posedge clk) begin
    if (!rst)
      csum_q <= '0;
    else if (start)
      csum_q <= '0;
    else if (take_hi | take_lo)
      csum_q <= csum_q ^ byte_in;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      load_addr <= '0;
    else if (start)
      load_addr <= '0;
    else if (state_q == WR && !last)
      load_addr <= load_addr + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = HI;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        HI:   if (hs) state_d = LO;
        LO:   if (hs) state_d = WR;
`ifdef LOADER_CHECKSUM_EN
        WR:   state_d = last ? CK : HI;
        CK:   if (ck_hs)
                state_d = (byte_in == csum_q) ? REL : ERR;
        ERR:  state_d = ERR;
`else
        WR:   state_d = last ? REL : HI;
`endif
        REL:  state_d = RUN;
        RUN:  if (cpu_done) state_d = HALT;
        HALT: state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    byte_ready = 1'b0;
    PC_rst     = 1'b1;
    busy       = 1'b0;
    running    = 1'b0;
    halted     = 1'b0;
    unique case (state_q)
      HI, LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      WR, REL: busy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      CK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
`endif
      RUN: begin
        PC_rst  = 1'b0;
        running = 1'b1;
      end
      HALT: begin
        PC_rst = 1'b0;
        halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
// Covers reset, full load, stalls, restart, run/halt, checksum option.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] ext_data;
  logic        ext_we;
  logic [2:0]  load_addr;
  logic        PC_rst;
  logic        cpu_done;
  logic        busy;
  logic        running;
  logic        halted;
`ifdef LOADER_CHECKSUM_EN
  logic        err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] wr_data [64];
  logic [2:0]  wr_addr [64];
  int          n_wr = 0;

  logic [15:0] prog [8] = '{
    16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0,
    16'h0F1E, 16'h2D3C, 16'h4B5A, 16'h6978
  };

  prog_loader #(.WORDS(8), .AW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .ext_data   (ext_data),
    .ext_we     (ext_we),
    .load_addr  (load_addr),
    .PC_rst     (PC_rst),
    .cpu_done   (cpu_done),
    .busy       (busy),
    .running    (running),
`ifdef LOADER_CHECKSUM_EN
    .err        (err),
`endif
    .halted     (halted)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && ext_we && n_wr < 64) begin
      wr_data[n_wr] = ext_data;
      wr_addr[n_wr] = load_addr;
      n_wr = n_wr + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: no summary reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present a byte and wait (bounded) for it to be taken.
  task automatic send(input logic [7:0] b);
    int k;
    byte_in    = b;
    byte_valid = 1'b1;
    k = 0;
    while (!byte_ready && k < 20) begin
      tick();
      k++;
    end
    chk("ready_wait", byte_ready, 1);
    tick();
  endtask

  initial begin
    int base;
    logic [7:0] xr;
    rst        = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    cpu_done   = 1'b0;

    // reset
    tick();
    tick();
    chk("rst_pcrst", PC_rst, 1);
    chk("rst_we", ext_we, 0);
    chk("rst_ready", byte_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", load_addr, 0);
    chk("rst_data", ext_data, 0);
    chk("rst_run", running, 0);
    chk("rst_halt", halted, 0);

    // full load with byte_valid held high
    rst = 1'b1;
    tick();
    base = n_wr;
    pulse_start();
    chk("ld_busy", busy, 1);
    xr = 8'h00;
    for (int i = 0; i < 8; i++) begin
      send(prog[i][15:8]);
      send(prog[i][7:0]);
      xr = xr ^ prog[i][15:8] ^ prog[i][7:0];
    end
    chk("ld_last_we", ext_we, 1);
    chk("ld_last_rdy", byte_ready, 0);
    chk("ld_last_pc", PC_rst, 1);
`ifdef LOADER_CHECKSUM_EN
    send(xr);
    byte_valid = 1'b0;
    chk("ck_rel_pc", PC_rst, 1);
    chk("ck_rel_err", err, 0);
    tick();
    chk("ck_run_pc", PC_rst, 0);
`else
    byte_valid = 1'b0;
    tick();
    chk("rel_pc", PC_rst, 1);
    chk("rel_busy", busy, 1);
    tick();
    chk("run_pc", PC_rst, 0);
`endif
    chk("run_running", running, 1);
    chk("run_busy", busy, 0);
    chk("ld_nwr", n_wr - base, 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ld_data%0d", i), wr_data[base+i], prog[i]);
      chk($sformatf("ld_addr%0d", i), wr_addr[base+i], i);
    end

    // run / halt
    cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    chk("halt_running", running, 0);
    chk("halt_halted", halted, 1);
    chk("halt_pc", PC_rst, 0);
    tick();
    chk("halt_hold", halted, 1);

    // stalled source with 3-cycle gaps
    base = n_wr;
    pulse_start();
    byte_in    = 8'hA5;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    byte_in    = 8'hFF;
    tick();
    tick();
    tick();
    chk("stall_hi", ext_data[15:8], 8'hA5);
    chk("stall_we", ext_we, 0);
    chk("stall_ready", byte_ready, 1);
    byte_in    = 8'h5A;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    chk("stall_word", ext_data, 16'hA55A);
    chk("stall_we1", ext_we, 1);
    chk("stall_addr", load_addr, 0);
    tick();
    chk("stall_addr1", load_addr, 1);
    chk("stall_nwr", n_wr - base, 1);

    // restart mid-load, start beating a handshake
    cpu_done = 1'b1;
    send(8'h11);
    send(8'h22);
    send(8'h33);
    chk("rs_addr2", load_addr, 2);
    start      = 1'b1;
    byte_valid = 1'b1;
    byte_in    = 8'hEE;
    tick();
    start      = 1'b0;
    byte_valid = 1'b0;
    chk("rs_addr0", load_addr, 0);
    chk("rs_data", ext_data, 16'h3322);
    chk("rs_we", ext_we, 0);
    chk("rs_pc", PC_rst, 1);
    chk("rs_busy", busy, 1);
    chk("rs_run", running, 0);
    chk("rs_halt", halted, 0);
    cpu_done = 1'b0;
    send(8'h44);
    send(8'h55);
    byte_valid = 1'b0;
    chk("rs_word", ext_data, 16'h4455);
    chk("rs_waddr", load_addr, 0);
    tick();
    chk("rs_nwr", n_wr - base, 3);
    chk("rs_d1", wr_data[base+1], 16'h1122);
    chk("rs_a1", wr_addr[base+1], 1);
    chk("rs_d2", wr_data[base+2], 16'h4455);
    chk("rs_a2", wr_addr[base+2], 0);

    // reset mid-load
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rm_busy", busy, 0);
    chk("rm_pc", PC_rst, 1);
    chk("rm_addr", load_addr, 0);
    chk("rm_data", ext_data, 0);

`ifdef LOADER_CHECKSUM_EN
    // wrong checksum byte
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      send(prog[i][15:8]);
      send(prog[i][7:0]);
    end
    send(xr ^ 8'h01);
    byte_valid = 1'b0;
    chk("ck_err", err, 1);
    chk("ck_err_pc", PC_rst, 1);
    tick();
    tick();
    chk("ck_err_hold", err, 1);
    chk("ck_err_pc2", PC_rst, 1);
    pulse_start();
    chk("ck_err_clr", err, 0);
    chk("ck_err_busy", busy, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
